// File: rtl/multi_clock_divider_if.sv
// Bus interface for multi_clock_divider: channel enables, sync, divisor writes and
// the per-channel divided outputs. The master drives controls; the slave is the divider.
interface multi_clock_divider_if #(
  parameter int CH = 4,
  parameter int CW = 32
);
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0] en;
  logic          sync;
  logic          div_wr;
  logic [SW-1:0] div_sel;
  logic [CW-1:0] div_val;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] div_pend;

  modport master (
    output en, sync, div_wr, div_sel, div_val,
    input  clk_out, tick, div_pend
  );

  modport slave (
    input  en, sync, div_wr, div_sel, div_val,
    output clk_out, tick, div_pend
  );
endinterface

// File: rtl/multi_clock_divider.sv
// CH independent programmable clock dividers with a common in-phase restart.
// Define DIV_SHADOW_EN to buffer divisor writes until the running period completes.
module multi_clock_divider #(
  parameter int          CH          = 4,
  parameter int          CW          = 32,
  parameter int unsigned DEFAULT_DIV = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_clock_divider_if.slave  bus
);
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] div_q_reg;
    logic [CW-1:0] d_eff;
    logic          clk_out_reg;
    logic          tick_reg;
    logic          evt;
    logic          wr_hit;

    // A zero divisor behaves as one so the channel can never stall.
    assign d_eff  = (div_q_reg == '0) ? CW'(1) : div_q_reg;
    // >= rather than == lets a shrunken divisor end the period immediately.
    assign evt    = bus.en[gi] && (cnt_reg >= d_eff - CW'(1));
    assign wr_hit = bus.div_wr && (bus.div_sel == SW'(gi));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg     <= '0;
        clk_out_reg <= 1'b0;
        tick_reg    <= 1'b0;
      end else if (bus.sync) begin
        cnt_reg     <= '0;
        clk_out_reg <= 1'b0;
        tick_reg    <= 1'b0;
      end else if (!bus.en[gi]) begin
        tick_reg    <= 1'b0;
      end else if (evt) begin
        cnt_reg     <= '0;
        clk_out_reg <= ~clk_out_reg;
        tick_reg    <= 1'b1;
      end else begin
        cnt_reg     <= cnt_reg + CW'(1);
        tick_reg    <= 1'b0;
      end
    end

`ifdef DIV_SHADOW_EN
    logic [CW-1:0] div_s_reg;
    logic          pend_reg;
    logic          load;

    // Safe moments to swap divisors: period boundary, restart, or idle channel.
    assign load = evt || bus.sync || !bus.en[gi];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        div_q_reg <= CW'(DEFAULT_DIV);
        div_s_reg <= CW'(DEFAULT_DIV);
        pend_reg  <= 1'b0;
      end else if (wr_hit) begin
        div_s_reg <= bus.div_val;
        if (load) begin
          div_q_reg <= bus.div_val;
          pend_reg  <= 1'b0;
        end else begin
          pend_reg  <= 1'b1;
        end
      end else if (load && pend_reg) begin
        div_q_reg <= div_s_reg;
        pend_reg  <= 1'b0;
      end
    end

    assign bus.div_pend[gi] = pend_reg;
`else
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        div_q_reg <= CW'(DEFAULT_DIV);
      end else if (wr_hit) begin
        div_q_reg <= bus.div_val;
      end
    end

    assign bus.div_pend[gi] = 1'b0;
`endif

    assign bus.clk_out[gi] = clk_out_reg;
    assign bus.tick[gi]    = tick_reg;
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: vector table, directed corner sequences
// and randomized traffic against a cycle-level reference model of the divider rules.
module tb_multi_clock_divider;
  localparam int CH = 3;
  localparam int CW = 16;
  localparam int DDIV = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   cyc;

  multi_clock_divider_if #(.CH(CH), .CW(CW)) bus ();

  multi_clock_divider #(.CH(CH), .CW(CW), .DEFAULT_DIV(DDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state, kept as plain integers per channel.
  int m_cnt  [CH];
  int m_clk  [CH];
  int m_tick [CH];
  int m_divq [CH];
  int m_divs [CH];
  int m_pend [CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      m_divq[c] = DDIV; m_divs[c] = DDIV; m_pend[c] = 0;
    end
  endtask

  task automatic model_step(input logic [CH-1:0] e, input logic s, input logic w,
                            input int sl, input int v);
    for (int c = 0; c < CH; c++) begin
      int  d;
      bit  ev;
      bit  hit;
      d   = (m_divq[c] == 0) ? 1 : m_divq[c];
      ev  = e[c] && (m_cnt[c] >= d - 1);
      hit = w && (sl == c);
`ifdef DIV_SHADOW_EN
      begin
        bit ld;
        ld = ev || s || !e[c];
        if (hit) begin
          m_divs[c] = v;
          if (ld) begin m_divq[c] = v; m_pend[c] = 0; end
          else m_pend[c] = 1;
        end else if (ld && m_pend[c] != 0) begin
          m_divq[c] = m_divs[c]; m_pend[c] = 0;
        end
      end
`else
      if (hit) m_divq[c] = v;
`endif
      if (s) begin
        m_cnt[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end else if (!e[c]) begin
        m_tick[c] = 0;
      end else if (ev) begin
        m_cnt[c] = 0; m_clk[c] = 1 - m_clk[c]; m_tick[c] = 1;
      end else begin
        m_cnt[c] = m_cnt[c] + 1; m_tick[c] = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [CH-1:0] ec, et, ep;
    for (int c = 0; c < CH; c++) begin
      ec[c] = (m_clk[c] != 0);
      et[c] = (m_tick[c] != 0);
      ep[c] = (m_pend[c] != 0);
    end
    check("model_clk_out", 32'(bus.clk_out), 32'(ec));
    check("model_tick", 32'(bus.tick), 32'(et));
    check("model_div_pend", 32'(bus.div_pend), 32'(ep));
  endtask

  // One clock: drive inputs, clock the DUT and the model, then sample 1ns later.
  task automatic cycle(input logic [CH-1:0] e, input logic s, input logic w,
                       input logic [1:0] sl, input logic [CW-1:0] v);
    bus.en = e; bus.sync = s; bus.div_wr = w; bus.div_sel = sl; bus.div_val = v;
    @(posedge clk);
    model_step(e, s, w, int'(sl), int'(v));
    #1;
    cyc++;
    $display("cyc %0d en=%b sync=%b wr=%b sel=%0d val=%0d -> clk_out=%b tick=%b pend=%b",
             cyc, e, s, w, sl, v, bus.clk_out, bus.tick, bus.div_pend);
    compare_model();
  endtask

  task automatic run(input logic [CH-1:0] e, input int n);
    for (int i = 0; i < n; i++) cycle(e, 1'b0, 1'b0, 2'd0, '0);
  endtask

  typedef struct {
    logic [CH-1:0] en;
    logic [CH-1:0] exp_tick;
    logic [CH-1:0] exp_clk;
  } vec_t;

  vec_t tbl [9];

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    tbl = '{
      '{3'b001, 3'b000, 3'b000}, '{3'b001, 3'b000, 3'b000}, '{3'b001, 3'b001, 3'b001},
      '{3'b001, 3'b000, 3'b001}, '{3'b001, 3'b000, 3'b001}, '{3'b001, 3'b001, 3'b000},
      '{3'b001, 3'b000, 3'b000}, '{3'b001, 3'b000, 3'b000}, '{3'b001, 3'b001, 3'b001}
    };

    rst = 1'b0;
    bus.en = '0; bus.sync = 1'b0; bus.div_wr = 1'b0; bus.div_sel = '0; bus.div_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_clk_out", 32'(bus.clk_out), 32'd0);
    check("reset_tick", 32'(bus.tick), 32'd0);
    check("reset_div_pend", 32'(bus.div_pend), 32'd0);
    rst = 1'b1;

    // Default divisor 3 on channel 0: ticks at 3,6,9, clk_out period 6.
    for (int k = 0; k < 9; k++) begin
      cycle(tbl[k].en, 1'b0, 1'b0, 2'd0, '0);
      check($sformatf("tbl%0d_tick", k + 1), 32'(bus.tick), 32'(tbl[k].exp_tick));
      check($sformatf("tbl%0d_clk", k + 1), 32'(bus.clk_out), 32'(tbl[k].exp_clk));
    end

    // Divisor 0 on channel 1 acts as 1: tick every cycle, clk_out = clk/2.
    cycle(3'b000, 1'b0, 1'b1, 2'd1, 16'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(3'b010, 1'b0, 1'b0, 2'd0, '0);
      check("d0_tick1", 32'(bus.tick[1]), 32'd1);
      check("d0_clk1", 32'(bus.clk_out[1]), 32'((k % 2) == 0));
    end

    // Divisor lowered from 10 to 4 while cnt=7.
    cycle(3'b000, 1'b0, 1'b1, 2'd0, 16'd10);
    cycle(3'b000, 1'b1, 1'b0, 2'd0, '0);
    run(3'b001, 7);
    cycle(3'b001, 1'b0, 1'b1, 2'd0, 16'd4);
    check("shrink_no_evt_yet", 32'(bus.tick[0]), 32'd0);
`ifdef DIV_SHADOW_EN
    check("shrink_pend", 32'(bus.div_pend[0]), 32'd1);
    cycle(3'b001, 1'b0, 1'b0, 2'd0, '0);
    check("shrink_cnt9_no_tick", 32'(bus.tick[0]), 32'd0);
`endif
    cycle(3'b001, 1'b0, 1'b0, 2'd0, '0);
    check("shrink_evt", 32'(bus.tick[0]), 32'd1);
    check("shrink_pend_clear", 32'(bus.div_pend[0]), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cycle(3'b001, 1'b0, 1'b0, 2'd0, '0);
      check("shrink_period4", 32'(bus.tick[0]), 32'(k == 4));
    end

    // Pause at cnt=2 with d=4: everything frozen, then event on 2nd enabled cycle.
    cycle(3'b000, 1'b1, 1'b0, 2'd0, '0);
    run(3'b001, 2);
    for (int k = 0; k < 5; k++) begin
      cycle(3'b000, 1'b0, 1'b0, 2'd0, '0);
      check("pause_tick", 32'(bus.tick[0]), 32'd0);
      check("pause_clk", 32'(bus.clk_out[0]), 32'd0);
    end
    cycle(3'b001, 1'b0, 1'b0, 2'd0, '0);
    check("resume_cnt3", 32'(bus.tick[0]), 32'd0);
    cycle(3'b001, 1'b0, 1'b0, 2'd0, '0);
    check("resume_evt", 32'(bus.tick[0]), 32'd1);
    check("resume_clk", 32'(bus.clk_out[0]), 32'd1);

    // Mixed phases, then sync: all cleared, equal divisors tick together.
    cycle(3'b000, 1'b0, 1'b1, 2'd1, 16'd4);
    cycle(3'b000, 1'b0, 1'b1, 2'd2, 16'd7);
    for (int k = 0; k < 7; k++) cycle(3'($urandom), 1'b0, 1'b0, 2'd0, '0);
    run(3'b101, 3);
    cycle(3'b111, 1'b1, 1'b0, 2'd0, '0);
    check("sync_clk_out", 32'(bus.clk_out), 32'd0);
    check("sync_tick", 32'(bus.tick), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cycle(3'b111, 1'b0, 1'b0, 2'd0, '0);
      check("sync_coincident", 32'(bus.tick[1:0]), (k == 4) ? 32'd3 : 32'd0);
    end

    // Out-of-range channel select must not disturb any divisor.
    cycle(3'b000, 1'b0, 1'b1, 2'd3, 16'd1);
    cycle(3'b000, 1'b1, 1'b0, 2'd0, '0);
    for (int k = 1; k <= 4; k++) begin
      cycle(3'b111, 1'b0, 1'b0, 2'd0, '0);
      check("badsel_tick", 32'(bus.tick), (k == 4) ? 32'd3 : 32'd0);
    end

    // Asynchronous reset mid-count clears outputs without waiting for an edge.
    run(3'b111, 3);
    #2;
    rst = 1'b0;
    #1;
    check("async_clk_out", 32'(bus.clk_out), 32'd0);
    check("async_tick", 32'(bus.tick), 32'd0);
    check("async_pend", 32'(bus.div_pend), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    compare_model();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(3'($urandom), ($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0),
            2'($urandom_range(0, 3)), 16'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
